wb_arbiter: RTL

//  Owns the single register_file write port (a3/wd3/we3). Merges the in-order core writeback with

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_arbiter_if.sv | 74 +++++++
 rtl/wb_fifo.sv | 62 ++++++
 rtl/wb_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter slice.
package wb_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    // One queued long-latency result: destination register and data.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wd;
    } wb_entry_t;

    // One-hot mask of a register index, used to set/clear scoreboard bits.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
        logic [NUM_REGS-1:0] m;
        m    = '0;
        m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the pipeline/register file and wb_arbiter.
//
// Handshake: the LU result channel is valid/ready. An entry transfers on
// a cycle where lu_valid && lu_ready at the rising clock edge. While
// lu_valid is high and lu_ready is low the producer holds lu_rd/lu_wd
// stable. lu_ready never depends on lu_valid in the same cycle.
//
// dbg_busy / dbg_count expose the scoreboard and FIFO occupancy so
// checkers can observe internal state without hierarchical references.
interface wb_arbiter_if #(
    parameter int DEPTH = 4
);
    import wb_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              core_we;
    logic [REG_AW-1:0] core_rd;
    logic [XLEN-1:0]   core_wd;

    logic              lu_valid;
    logic              lu_ready;
    logic [REG_AW-1:0] lu_rd;
    logic [XLEN-1:0]   lu_wd;

    logic              issue_valid;
    logic [REG_AW-1:0] issue_rd;

    logic [REG_AW-1:0] dec_rs1;
    logic [REG_AW-1:0] dec_rs2;
    logic [REG_AW-1:0] dec_rd;
    logic              stall;
    logic              wb_hold;

    logic [REG_AW-1:0] rf_a3;
    logic [XLEN-1:0]   rf_wd3;
    logic              rf_we3;
    logic [XLEN-1:0]   rf_rd1;
    logic [XLEN-1:0]   rf_rd2;
    logic [XLEN-1:0]   op_rd1;
    logic [XLEN-1:0]   op_rd2;

    logic [NUM_REGS-1:0] dbg_busy;
    logic [CNT_W-1:0]    dbg_count;

    // Arbiter side.
    modport slave (
        input  core_we, core_rd, core_wd,
        input  lu_valid, lu_rd, lu_wd,
        output lu_ready,
        input  issue_valid, issue_rd,
        input  dec_rs1, dec_rs2, dec_rd,
        output stall, wb_hold,
        output rf_a3, rf_wd3, rf_we3,
        input  rf_rd1, rf_rd2,
        output op_rd1, op_rd2,
        output dbg_busy, dbg_count
    );

    // Pipeline / register-file side.
    modport master (
        output core_we, core_rd, core_wd,
        output lu_valid, lu_rd, lu_wd,
        input  lu_ready,
        output issue_valid, issue_rd,
        output dec_rs1, dec_rs2, dec_rd,
        input  stall, wb_hold,
        input  rf_a3, rf_wd3, rf_we3,
        output rf_rd1, rf_rd2,
        input  op_rd1, op_rd2,
        input  dbg_busy, dbg_count
    );

endinterface

// File: rtl/wb_fifo.sv
// Small FIFO of queued long-latency results. DEPTH must be a power of 2
// so the read/write pointers wrap naturally. Push when full and pop when
// empty are ignored.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head,
    output logic [CW-1:0] count
);

    wb_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Entry storage: written on accepted push, contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: owns the single register-file write port. The core
// writeback has priority; queued long-latency results drain into idle
// slots. A busy scoreboard produces the decode stall, and a starvation
// counter raises wb_hold so the core yields a slot.
//
// Optional feature macro: WB_BYPASS_EN -- same-cycle write-through of
// the port write onto the decode operands. Undefined: pure pass-through.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic              core_owns;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    wb_entry_t         fifo_head;
    wb_entry_t         push_entry;
    logic [CW-1:0]     fifo_count;

    logic              sel_we;
    logic [REG_AW-1:0] sel_a3;
    logic [XLEN-1:0]   sel_wd;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [SW-1:0]       starve_cnt;
    logic                wb_hold_q;

    // A core write to x0 is dropped and leaves the slot free for the FIFO.
    assign core_owns  = bus.core_we && (bus.core_rd != '0);

    // lu_ready comes only from registered occupancy; x0 results are accepted
    // on the handshake but never enqueued.
    assign bus.lu_ready = !fifo_full;
    assign fifo_push    = bus.lu_valid && !fifo_full && (bus.lu_rd != '0);
    assign push_entry   = '{rd: bus.lu_rd, wd: bus.lu_wd};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // Write-port select: core first, else drain FIFO head; nothing while in reset.
    always_comb begin
        sel_we   = 1'b0;
        sel_a3   = '0;
        sel_wd   = '0;
        fifo_pop = 1'b0;
        if (rst_n) begin
            if (core_owns) begin
                sel_we = 1'b1;
                sel_a3 = bus.core_rd;
                sel_wd = bus.core_wd;
            end else if (!fifo_empty) begin
                sel_we   = 1'b1;
                sel_a3   = fifo_head.rd;
                sel_wd   = fifo_head.wd;
                fifo_pop = 1'b1;
            end
        end
    end

    assign bus.rf_we3 = sel_we;
    assign bus.rf_a3  = sel_a3;
    assign bus.rf_wd3 = sel_wd;

    // Scoreboard next state: clear on drain, then set on issue so a
    // same-cycle re-issue of the drained register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (fifo_pop) begin
            busy_d = busy_d & ~reg_onehot(fifo_head.rd);
        end
        if (bus.issue_valid && (bus.issue_rd != '0)) begin
            busy_d = busy_d | reg_onehot(bus.issue_rd);
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.stall = busy_q[bus.dec_rs1] | busy_q[bus.dec_rs2] | busy_q[bus.dec_rd];

    // Starvation counter: counts cycles the FIFO waits behind the core, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (fifo_empty || fifo_pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    assign wb_hold_q   = (starve_cnt == SW'(STARVE_MAX));
    assign bus.wb_hold = wb_hold_q;

    // Operand path toward execute.
`ifdef WB_BYPASS_EN
    assign bus.op_rd1 = (sel_we && (sel_a3 != '0) && (sel_a3 == bus.dec_rs1)) ? sel_wd : bus.rf_rd1;
    assign bus.op_rd2 = (sel_we && (sel_a3 != '0) && (sel_a3 == bus.dec_rs2)) ? sel_wd : bus.rf_rd2;
`else
    assign bus.op_rd1 = bus.rf_rd1;
    assign bus.op_rd2 = bus.rf_rd2;
`endif

    assign bus.dbg_busy  = busy_q;
    assign bus.dbg_count = fifo_count;

    // Issuing to a busy register is only legal when that register drains this cycle.
    a_issue_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.issue_valid && (bus.issue_rd != '0)) |->
            (!busy_q[bus.issue_rd] || (fifo_pop && (fifo_head.rd == bus.issue_rd))));

    // The core must yield the port while wb_hold is raised.
    a_core_respects_hold: assert property (@(posedge clk) disable iff (!rst_n)
        wb_hold_q |-> !bus.core_we);

endmodule
